rotate_undo: RTL and testbench

//  Inverse companion of rotate100. Shadows the rotator's load/ena controls,

---
 rtl/rotate_pkg.sv | 17 +
 rtl/barrel_ror.sv | 32 +++
 rtl/rotate_undo.sv | 98 +++++++++
 tb/tb_rotate_undo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared constants and types for the rotator and its inverse self-check.
package rotate_pkg;

  localparam int unsigned ROT_WIDTH = 100;

  localparam logic [1:0] ROT_HOLD  = 2'b00;
  localparam logic [1:0] ROT_RIGHT = 2'b01;
  localparam logic [1:0] ROT_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    RotHold     = ROT_HOLD,
    RotRight    = ROT_RIGHT,
    RotLeft     = ROT_LEFT,
    RotHoldBoth = 2'b11
  } rot_dir_e;

endpackage

// File: rtl/barrel_ror.sv
// Combinational rotate-right of a WIDTH-bit word by amt (mod WIDTH),
// built from log2 stages of constant rotations.
module barrel_ror #(
  parameter  int unsigned WIDTH = 100,
  localparam int unsigned OFF_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [OFF_W-1:0] amt,
  output logic [WIDTH-1:0] dout
);

  logic [OFF_W-1:0] amt_c;
  logic [WIDTH-1:0] stage [OFF_W+1];

  // Fold amounts in [WIDTH, 2**OFF_W) back into range; one subtraction suffices.
  assign amt_c = (amt >= OFF_W'(WIDTH)) ? amt - OFF_W'(WIDTH) : amt;

  assign stage[0] = din;

  for (genvar i = 0; i < OFF_W; i++) begin : g_stage
    localparam int unsigned S = (2 ** i) % WIDTH;
    if (S == 0) begin : g_pass
      assign stage[i+1] = stage[i];
    end else begin : g_rot
      assign stage[i+1] = amt_c[i] ? ((stage[i] >> S) | (stage[i] << (WIDTH - S)))
                                   : stage[i];
    end
  end

  assign dout = stage[OFF_W];

endmodule

// File: rtl/rotate_undo.sv
// Inverse companion of rotate100: tracks net rotation, de-rotates the rotator
// output back to the loaded word and raises a sticky flag on any divergence.
module rotate_undo
  import rotate_pkg::*;
#(
  parameter  int unsigned WIDTH = ROT_WIDTH,
  localparam int unsigned OFF_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [1:0]       ena,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] q_rot,
  input  logic             clr_err,
  output logic [OFF_W-1:0] offset,
  output logic [WIDTH-1:0] q_orig,
  output logic             q_valid,
  output logic             mismatch
);

  localparam logic [OFF_W-1:0] OffMax = OFF_W'(WIDTH - 1);

  logic [OFF_W-1:0] offset_q, offset_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic [WIDTH-1:0] golden_dly_q;
  logic [WIDTH-1:0] q_orig_q, q_orig_d;
  logic             armed_q, armed_d;
  logic             q_valid_q;
  logic             load_dly_q;
  logic             mismatch_q, mismatch_d;
  logic             chk_fail;

  barrel_ror #(
    .WIDTH (WIDTH)
  ) u_ror (
    .din  (q_rot),
    .amt  (offset_q),
    .dout (q_orig_d)
  );

  always_comb begin
    offset_d = offset_q;
    golden_d = golden_q;
    armed_d  = armed_q;
    if (load) begin
      offset_d = '0;
      golden_d = data;
      armed_d  = 1'b1;
    end else begin
      case (rot_dir_e'(ena))
        RotLeft:  offset_d = (offset_q == OffMax) ? '0 : offset_q + OFF_W'(1);
        RotRight: offset_d = (offset_q == '0) ? OffMax : offset_q - OFF_W'(1);
        default:  offset_d = offset_q;
      endcase
    end
  end

  // The cycle right after a load still shows the pre-load word, so skip it.
  assign chk_fail = q_valid_q && !load_dly_q && (q_orig_q != golden_dly_q);

  always_comb begin
    mismatch_d = mismatch_q;
    if (chk_fail) begin
      mismatch_d = 1'b1;
    end else if (clr_err) begin
      mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      offset_q     <= '0;
      golden_q     <= '0;
      golden_dly_q <= '0;
      q_orig_q     <= '0;
      armed_q      <= 1'b0;
      q_valid_q    <= 1'b0;
      load_dly_q   <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      offset_q     <= offset_d;
      golden_q     <= golden_d;
      golden_dly_q <= golden_q;
      q_orig_q     <= q_orig_d;
      armed_q      <= armed_d;
      q_valid_q    <= armed_q;
      load_dly_q   <= load;
      mismatch_q   <= mismatch_d;
    end
  end

  assign offset   = offset_q;
  assign q_orig   = q_orig_q;
  assign q_valid  = q_valid_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_rotate_undo.sv
// Directed bench for rotate_undo beside a behavioural rotate100 model.
module tb_rotate_undo;

  localparam int unsigned W = 100;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           load = 1'b0;
  logic [1:0]     ena = 2'b00;
  logic [W-1:0]   data = '0;
  logic [W-1:0]   q_rot;
  logic           clr_err = 1'b0;
  logic [6:0]     offset;
  logic [W-1:0]   q_orig;
  logic           q_valid;
  logic           mismatch;

  logic [W-1:0]   rot_q = '0;
  logic           flip = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // rotate100 reference: 01 rotates right, 10 rotates left; never reset.
  always_ff @(posedge clk) begin
    if (load) rot_q <= data;
    else if (ena == 2'b01) rot_q <= {rot_q[0], rot_q[W-1:1]};
    else if (ena == 2'b10) rot_q <= {rot_q[W-2:0], rot_q[W-1]};
  end

  assign q_rot = rot_q ^ {{(W-1){1'b0}}, flip};

  rotate_undo #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .ena      (ena),
    .data     (data),
    .q_rot    (q_rot),
    .clr_err  (clr_err),
    .offset   (offset),
    .q_orig   (q_orig),
    .q_valid  (q_valid),
    .mismatch (mismatch)
  );

  typedef struct {
    logic         load;
    logic [1:0]   ena;
    logic [W-1:0] data;
    logic [6:0]   exp_off;
    logic         exp_valid;
    logic         exp_mis;
    logic         chk_q;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic [1:0] e, input logic [W-1:0] d);
    load = l;
    ena  = e;
    data = d;
  endtask

  initial begin
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    logic [W-1:0] wc;
    wa = 100'hafffffffffffffffffffffffa;
    wb = 100'h5;
    wc = 100'h123456789abcdef0123456789;

    // Tests 1, 2 and 4 as one continuous sequence.
    vecs[0]  = '{1'b1, 2'b00, 100'h1, 7'd0,  1'b0, 1'b0, 1'b0, '0};
    vecs[1]  = '{1'b0, 2'b10, '0,     7'd1,  1'b1, 1'b0, 1'b1, 100'h1};
    vecs[2]  = '{1'b0, 2'b10, '0,     7'd2,  1'b1, 1'b0, 1'b1, 100'h1};
    vecs[3]  = '{1'b0, 2'b10, '0,     7'd3,  1'b1, 1'b0, 1'b1, 100'h1};
    vecs[4]  = '{1'b0, 2'b00, '0,     7'd3,  1'b1, 1'b0, 1'b1, 100'h1};
    vecs[5]  = '{1'b1, 2'b01, wa,     7'd0,  1'b1, 1'b0, 1'b1, 100'h1};
    vecs[6]  = '{1'b0, 2'b01, '0,     7'd99, 1'b1, 1'b0, 1'b1, wa};
    vecs[7]  = '{1'b0, 2'b00, '0,     7'd99, 1'b1, 1'b0, 1'b1, wa};
    vecs[8]  = '{1'b1, 2'b10, wb,     7'd0,  1'b1, 1'b0, 1'b1, wa};
    vecs[9]  = '{1'b0, 2'b00, '0,     7'd0,  1'b1, 1'b0, 1'b1, wb};
    vecs[10] = '{1'b0, 2'b11, '0,     7'd0,  1'b1, 1'b0, 1'b1, wb};
    vecs[11] = '{1'b0, 2'b00, '0,     7'd0,  1'b1, 1'b0, 1'b1, wb};

    #12;
    chk("rst_offset",   W'(offset), '0);
    chk("rst_q_orig",   q_orig,     '0);
    chk("rst_q_valid",  W'(q_valid), '0);
    chk("rst_mismatch", W'(mismatch), '0);
    @(negedge clk);
    resetn = 1'b1;

    // Before any load nothing may arm or flag, even with a corrupted q_rot.
    flip = 1'b1;
    drive(1'b0, 2'b10, '0);
    tick(); tick(); tick();
    chk("preload_valid",    W'(q_valid),  '0);
    chk("preload_mismatch", W'(mismatch), '0);
    chk("preload_offset",   W'(offset),   W'(3));
    flip = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].ena, vecs[i].data);
      tick();
      chk($sformatf("vec%0d_offset", i),   W'(offset),   W'(vecs[i].exp_off));
      chk($sformatf("vec%0d_valid", i),    W'(q_valid),  W'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_mismatch", i), W'(mismatch), W'(vecs[i].exp_mis));
      if (vecs[i].chk_q) chk($sformatf("vec%0d_q_orig", i), q_orig, vecs[i].exp_q);
    end

    // Test 3: a full turn of left rotations returns offset to zero.
    drive(1'b1, 2'b00, wc);
    tick();
    drive(1'b0, 2'b10, '0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("turn%0d_offset", i), W'(offset), W'((i + 1) % 100));
      chk($sformatf("turn%0d_q_orig", i), q_orig, wc);
      chk($sformatf("turn%0d_mismatch", i), W'(mismatch), '0);
    end
    drive(1'b0, 2'b00, '0);
    tick();
    chk("turn_end_q_orig", q_orig, wc);
    chk("turn_end_q_rot",  q_rot,  wc);
    chk("turn_end_offset", W'(offset), '0);

    // Test 5: single-cycle corruption, sticky flag, then clear.
    flip = 1'b1;
    tick();
    flip = 1'b0;
    chk("err_edge1", W'(mismatch), '0);
    tick();
    chk("err_edge2", W'(mismatch), W'(1));
    tick(); tick();
    chk("err_sticky", W'(mismatch), W'(1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err_cleared", W'(mismatch), '0);
    tick();
    chk("err_stays_clear", W'(mismatch), '0);

    // Set beats clear on the same edge.
    flip = 1'b1;
    tick();
    flip = 1'b0;
    clr_err = 1'b1;
    tick();
    chk("set_wins", W'(mismatch), W'(1));
    tick();
    clr_err = 1'b0;
    chk("clear_after_set", W'(mismatch), '0);

    // Test 6: async reset mid-rotation with the flag set.
    drive(1'b1, 2'b00, wb);
    tick();
    drive(1'b0, 2'b10, '0);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 2'b00, '0);
    flip = 1'b1;
    tick(); tick();
    flip = 1'b0;
    chk("pre_rst_offset",   W'(offset),   W'(5));
    chk("pre_rst_mismatch", W'(mismatch), W'(1));
    resetn = 1'b0;
    #1;
    chk("mid_rst_offset",   W'(offset),   '0);
    chk("mid_rst_valid",    W'(q_valid),  '0);
    chk("mid_rst_mismatch", W'(mismatch), '0);
    chk("mid_rst_q_orig",   q_orig,       '0);
    #1;
    resetn = 1'b1;
    flip = 1'b1;
    drive(1'b0, 2'b10, '0);
    tick(); tick(); tick();
    flip = 1'b0;
    chk("post_rst_valid",    W'(q_valid),  '0);
    chk("post_rst_mismatch", W'(mismatch), '0);
    chk("post_rst_offset",   W'(offset),   W'(3));

    drive(1'b1, 2'b00, wa);
    tick();
    drive(1'b0, 2'b01, '0);
    tick();
    chk("rearm_valid",  W'(q_valid), W'(1));
    chk("rearm_q_orig", q_orig, wa);
    chk("rearm_offset", W'(offset), W'(99));
    drive(1'b0, 2'b00, '0);
    tick(); tick();
    chk("rearm_q_orig2",   q_orig, wa);
    chk("rearm_mismatch",  W'(mismatch), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
